// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and grant encoding for the writeback arbiter
package rf_pkg;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 2 ** AW;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write flags, set on alloc, cleared on writeback
module rf_scoreboard #(
    parameter int AW = rf_pkg::AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_alloc_valid,
    input  logic [AW-1:0]     i_alloc_ptr,
    input  logic              i_clr_valid,
    input  logic [AW-1:0]     i_clr_ptr,
    output logic [2**AW-1:0]  o_busy
);

    localparam int NR = 2 ** AW;

    logic [NR-1:0] r_busy;
    logic [NR-1:0] w_set;
    logic [NR-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_alloc_valid) w_set[i_alloc_ptr] = 1'b1;
        if (i_clr_valid)   w_clr[i_clr_ptr]   = 1'b1;
    end

    // Set is applied after clear so an alloc racing a writeback keeps the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - round-robin ALU/LSU writeback arbiter with registered register-file write port
module rf_wb_arb #(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_ptr,
    input  logic [DW-1:0]     alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [AW-1:0]     lsu_ptr,
    input  logic [DW-1:0]     lsu_data,
    output logic              lsu_ready,
    input  logic              alloc_valid,
    input  logic [AW-1:0]     alloc_ptr,
    output logic              rf_we,
    output logic [AW-1:0]     rf_ptr_w,
    output logic [DW-1:0]     rf_di,
    output logic [2**AW-1:0]  busy
);

    import rf_pkg::*;

    grant_e        r_last_grant;
    logic          r_we;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_di;
    logic          w_gnt_alu;
    logic          w_gnt_lsu;

    // Contention goes to whichever port did not win last; readies never look at ptr/data.
    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_lsu = 1'b0;
        if (!reset) begin
            w_gnt_alu = alu_valid && (!lsu_valid || (r_last_grant == GNT_LSU));
            w_gnt_lsu = lsu_valid && (!alu_valid || (r_last_grant == GNT_ALU));
        end
    end

    assign alu_ready = w_gnt_alu;
    assign lsu_ready = w_gnt_lsu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GNT_LSU;
            r_we         <= 1'b0;
            r_ptr        <= '0;
            r_di         <= '0;
        end else begin
            r_we <= w_gnt_alu || w_gnt_lsu;
            if (w_gnt_alu) begin
                r_last_grant <= GNT_ALU;
                r_ptr        <= alu_ptr;
                r_di         <= alu_data;
            end else if (w_gnt_lsu) begin
                r_last_grant <= GNT_LSU;
                r_ptr        <= lsu_ptr;
                r_di         <= lsu_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_ptr_w = r_ptr;
    assign rf_di    = r_di;

    rf_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_alloc_valid (alloc_valid),
        .i_alloc_ptr   (alloc_ptr),
        .i_clr_valid   (r_we),
        .i_clr_ptr     (r_ptr),
        .o_busy        (busy)
    );

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - self-checking bench for rf_wb_arb
module tb_rf_wb_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_valid = 1'b0;
    logic [2:0] alu_ptr = '0;
    logic [7:0] alu_data = '0;
    logic       alu_ready;
    logic       lsu_valid = 1'b0;
    logic [2:0] lsu_ptr = '0;
    logic [7:0] lsu_data = '0;
    logic       lsu_ready;
    logic       alloc_valid = 1'b0;
    logic [2:0] alloc_ptr = '0;
    logic       rf_we;
    logic [2:0] rf_ptr_w;
    logic [7:0] rf_di;
    logic [7:0] busy;

    int checks = 0;
    int failures = 0;

    rf_wb_arb #(.DW(8), .AW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ptr     (alu_ptr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_ptr     (lsu_ptr),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .alloc_valid (alloc_valid),
        .alloc_ptr   (alloc_ptr),
        .rf_we       (rf_we),
        .rf_ptr_w    (rf_ptr_w),
        .rf_di       (rf_di),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       av;
        bit [2:0] ap;
        bit [7:0] ad;
        bit       lv;
        bit [2:0] lp;
        bit [7:0] ld;
        bit       cv;
        bit [2:0] cp;
        bit       e_ar;
        bit       e_lr;
        bit       e_we;
        bit [2:0] e_ptr;
        bit [7:0] e_di;
        bit [7:0] e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic row(input bit rst, input bit av, input bit [2:0] ap, input bit [7:0] ad,
                       input bit lv, input bit [2:0] lp, input bit [7:0] ld,
                       input bit cv, input bit [2:0] cp,
                       input bit ear, input bit elr, input bit ewe,
                       input bit [2:0] eptr, input bit [7:0] edi, input bit [7:0] ebusy);
        vec_t v;
        v.rst = rst; v.av = av; v.ap = ap; v.ad = ad; v.lv = lv; v.lp = lp; v.ld = ld;
        v.cv = cv; v.cp = cp; v.e_ar = ear; v.e_lr = elr; v.e_we = ewe;
        v.e_ptr = eptr; v.e_di = edi; v.e_busy = ebusy;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; lsu_valid = 1'b0; alloc_valid = 1'b0;
    endtask

    // Pulse reset with requests pending; readies must stay low throughout.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        @(negedge clk);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b0;
    endtask

    // Reference model state: last winner (0=ALU,1=LSU), registered write, busy flags.
    int       m_last;
    bit       m_we;
    bit [2:0] m_ptr;
    bit [7:0] m_di;
    bit       m_busy[8];

    function automatic int pick(input bit av, input bit lv, input int last);
        if (av && lv) return (last == 1) ? 0 : 1;
        if (av) return 0;
        if (lv) return 1;
        return -1;
    endfunction

    initial begin
        int g;
        bit apend, lpend;
        bit [2:0] ap_r, lp_r;
        bit [7:0] ad_r, ld_r, busy_exp;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        //   rst av ap    ad     lv lp    ld     cv cp    ar lr we ptr   di     busy
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        row(0, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0, 3'd0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 1, 3'd3, 8'h5A, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd3, 8'h5A, 8'h00);
        row(1, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 3'd0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
        row(0, 1, 3'd1, 8'h33, 1, 3'd2, 8'h22, 0, 3'd0, 0, 1, 1, 3'd1, 8'h11, 8'h00);
        row(0, 1, 3'd1, 8'h33, 1, 3'd2, 8'h44, 0, 3'd0, 1, 0, 1, 3'd2, 8'h22, 8'h00);
        row(0, 0, 3'd0, 8'h00, 1, 3'd2, 8'h44, 0, 3'd0, 0, 1, 1, 3'd1, 8'h33, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 1, 3'd2, 8'h44, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd2, 8'h44, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd5, 0, 0, 0, 3'd2, 8'h44, 8'h00);
        row(0, 0, 3'd0, 8'h00, 1, 3'd5, 8'h77, 0, 3'd0, 0, 1, 0, 3'd2, 8'h44, 8'h20);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 1, 3'd5, 8'h77, 8'h20);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd5, 8'h77, 8'h00);
        row(0, 1, 3'd4, 8'h99, 0, 3'd0, 8'h00, 1, 3'd4, 1, 0, 0, 3'd5, 8'h77, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd4, 0, 0, 1, 3'd4, 8'h99, 8'h10);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd4, 8'h99, 8'h10);
        row(1, 1, 3'd6, 8'hAA, 1, 3'd6, 8'hBB, 0, 3'd0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
        row(0, 0, 3'd0, 8'h00, 1, 3'd6, 8'hBB, 0, 3'd0, 0, 1, 1, 3'd6, 8'hAA, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 1, 3'd6, 8'hBB, 8'h00);
        row(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 0, 0, 0, 3'd6, 8'hBB, 8'h00);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) do_reset();
            alu_valid = vq[i].av; alu_ptr = vq[i].ap; alu_data = vq[i].ad;
            lsu_valid = vq[i].lv; lsu_ptr = vq[i].lp; lsu_data = vq[i].ld;
            alloc_valid = vq[i].cv; alloc_ptr = vq[i].cp;
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vq[i].e_ar);
            chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vq[i].e_lr);
            chk($sformatf("v%0d_rf_we", i), rf_we, vq[i].e_we);
            chk($sformatf("v%0d_rf_ptr_w", i), rf_ptr_w, vq[i].e_ptr);
            chk($sformatf("v%0d_rf_di", i), rf_di, vq[i].e_di);
            chk($sformatf("v%0d_busy", i), busy, vq[i].e_busy);
            @(posedge clk); #1;
        end
        idle_inputs();

        // Asynchronous reset landing mid-cycle right after a transfer.
        alu_valid = 1'b1; alu_ptr = 3'd3; alu_data = 8'h3C;
        alloc_valid = 1'b1; alloc_ptr = 3'd3;
        @(negedge clk);
        chk("ar_pre_ready", alu_ready, 1);
        @(posedge clk); #1;
        alloc_valid = 1'b0;
        chk("ar_pre_we", rf_we, 1);
        chk("ar_pre_busy", busy, 8'h08);
        #2 reset = 1'b1;
        #1;
        chk("ar_rf_we", rf_we, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rf_ptr_w", rf_ptr_w, 0);
        chk("ar_rf_di", rf_di, 0);
        chk("ar_alu_ready", alu_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        alu_valid = 1'b0;
        @(negedge clk);
        chk("ar_post_we0", rf_we, 0);
        @(posedge clk); #1;
        chk("ar_post_we1", rf_we, 0);
        chk("ar_post_busy", busy, 0);

        // Randomized traffic against the model; requesters hold until granted.
        do_reset();
        m_last = 1; m_we = 0; m_ptr = 0; m_di = 0;
        foreach (m_busy[k]) m_busy[k] = 0;
        apend = 0; lpend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!apend && ($urandom % 3 == 0)) begin
                apend = 1; ap_r = 3'($urandom); ad_r = 8'($urandom);
            end
            if (!lpend && ($urandom % 3 == 0)) begin
                lpend = 1; lp_r = 3'($urandom); ld_r = 8'($urandom);
            end
            alu_valid = apend; alu_ptr = ap_r; alu_data = ad_r;
            lsu_valid = lpend; lsu_ptr = lp_r; lsu_data = ld_r;
            alloc_valid = ($urandom % 4 == 0);
            alloc_ptr = 3'($urandom);
            @(negedge clk);
            g = pick(apend, lpend, m_last);
            for (int k = 0; k < 8; k++) busy_exp[k] = m_busy[k];
            chk("rnd_alu_ready", alu_ready, (g == 0) ? 1 : 0);
            chk("rnd_lsu_ready", lsu_ready, (g == 1) ? 1 : 0);
            chk("rnd_rf_we", rf_we, m_we);
            chk("rnd_rf_ptr_w", rf_ptr_w, m_ptr);
            chk("rnd_rf_di", rf_di, m_di);
            chk("rnd_busy", busy, busy_exp);
            if (m_we) m_busy[m_ptr] = 0;
            if (alloc_valid) m_busy[alloc_ptr] = 1;
            m_we = (g >= 0);
            if (g == 0) begin
                m_last = 0; m_ptr = ap_r; m_di = ad_r; apend = 0;
            end else if (g == 1) begin
                m_last = 1; m_ptr = lp_r; m_di = ld_r; lpend = 0;
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter DW, default 8, meaning register data width.
REQ-002 SHALL have parameter AW, default 3, meaning register pointer width (2**AW registers).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid input 1, alu_ptr input AW, alu_data input DW, alu_ready output 1: ALU writeback request.
REQ-006 SHALL have ports lsu_valid input 1, lsu_ptr input AW, lsu_data input DW, lsu_ready output 1: load writeback request.
REQ-007 SHALL have ports alloc_valid input 1, alloc_ptr input AW: decode marks destination register pending.
REQ-008 SHALL have ports rf_we output 1, rf_ptr_w output AW, rf_di output DW: register-file write port drive.
REQ-009 SHALL have port busy  output 2**AW  per-register pending-write flags.

Function
REQ-010 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high in the same cycle.
REQ-011 SHALL derive alu_ready/lsu_ready combinationally from the valids and last_grant state, with no dependence on data or ptr.
REQ-012 SHALL grant the sole valid requester when only one is valid.
REQ-013 SHALL, when both are valid, grant the requester not equal to last_grant (round-robin).
REQ-014 SHALL update last_grant to the granted requester on every transfer; it holds otherwise.
REQ-015 SHALL register the winner: the cycle after a transfer, rf_we=1 with rf_ptr_w/rf_di equal to the granted ptr/data (latency 1).
REQ-016 SHALL drive rf_we=0 in any cycle following a cycle with no transfer; rf_ptr_w/rf_di hold their last value.
REQ-017 SHALL require requesters to hold valid, ptr and data stable until transfer; a loser keeps valid and wins the next cycle.
REQ-018 SHALL set busy[alloc_ptr] on the edge where alloc_valid=1.
REQ-019 SHALL clear busy[rf_ptr_w] on the edge where rf_we=1.
REQ-020 SHALL, if set and clear target the same register on the same edge, leave busy set (set wins).
REQ-021 SHALL accept same-pointer requests from both ports; they serialize in grant order and the later write overwrites.
REQ-022 SHALL not check busy before granting; stall decisions belong to decode.

Reset
REQ-023 SHALL, while reset=1, force rf_we=0, rf_ptr_w=0, rf_di=0, busy=0 and last_grant=LSU, so the ALU wins the first contention.
REQ-024 SHALL, on reset mid-operation, discard any registered write (rf_we=0 the next cycle, no register-file write).
REQ-025 SHALL keep alu_ready/lsu_ready at 0 while reset=1.

Structure
REQ-026 SHALL take DW, AW, NREG and a grant enum {GNT_ALU, GNT_LSU} from shared package rf_pkg.
REQ-027 SHALL place the busy scoreboard in sub-module rf_scoreboard (alloc set, writeback clear, set-wins rule); arbitration and output register remain in rf_wb_arb.

Verification
REQ-028 SHALL cover: ALU only, ptr=3, data=0x5A -> alu_ready=1 same cycle; next cycle rf_we=1, rf_ptr_w=3, rf_di=0x5A.
REQ-029 SHALL cover: after reset, ALU (ptr 1, 0x11) and LSU (ptr 2, 0x22) valid together -> ALU writes cycle+1, LSU writes cycle+2; with both held valid, grants alternate ALU, LSU, ALU.
REQ-030 SHALL cover: alloc ptr 5, then LSU write ptr 5 -> busy[5]=1 after alloc, 0 the edge after rf_we for ptr 5.
REQ-031 SHALL cover: alloc ptr 4 on the same edge as rf_we to ptr 4 -> busy[4] stays 1.
REQ-032 SHALL cover: both ports ptr 6, ALU 0xAA, LSU 0xBB, fresh reset -> rf writes 0xAA then 0xBB to r6.
REQ-033 SHALL cover: reset asserted asynchronously mid-cycle after a transfer -> rf_we=0 immediately, busy=0, no write follows.
